// File: rtl/psf_axi_arb2_if.sv
// AXI4 bundle (32-bit address/data, 4-bit ID, 8-bit len) shared by the
// upstream CPU ports and the merged downstream port of the arbiter.
interface psf_axi_arb2_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [2:0]  arsize;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  // Issues requests, consumes responses.
  modport master (
    output arvalid, araddr, arid, arlen, arburst, arsize,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awburst, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  // Accepts requests, produces responses.
  modport slave (
    input  arvalid, araddr, arid, arlen, arburst, arsize,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awburst, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/psf_axi_arb2.sv
// Two-port AXI4 arbiter: merges the instruction-fetch and data master ports
// into one master port. Read and write channels arbitrate independently,
// round-robin, one outstanding transaction each, grant held to the last response.
module psf_axi_arb2 (
  input  logic            clk_i,
  input  logic            rst_i,
  psf_axi_arb2_if.slave   mem_i,
  psf_axi_arb2_if.slave   mem_d,
  psf_axi_arb2_if.master  axi
);

  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;

  // Grant/pointer encoding: 0 = mem_i, 1 = mem_d.
  rd_state_e rd_state_q;
  logic      rd_gnt_q;
  logic      rd_ptr_q;
  wr_state_e wr_state_q;
  logic      wr_gnt_q;
  logic      wr_ptr_q;

  logic rd_arvalid, rd_rready, rd_ar_hs, rd_last_hs;
  logic wr_awvalid, wr_wvalid, wr_bready, wr_aw_hs, wr_last_hs, wr_b_hs;

  // On a tie the port not granted last wins; otherwise the lone requester.
  function automatic logic pick(input logic req_a, input logic req_b, input logic last_b);
    return (req_a & req_b) ? ~last_b : req_b;
  endfunction

  assign rd_ar_hs   = rd_arvalid & axi.arready;
  assign rd_last_hs = (rd_state_q == RData) & axi.rvalid & rd_rready & axi.rlast;
  assign wr_aw_hs   = wr_awvalid & axi.awready;
  assign wr_last_hs = wr_wvalid & axi.wready & (wr_gnt_q ? mem_d.wlast : mem_i.wlast);
  assign wr_b_hs    = (wr_state_q == WResp) & axi.bvalid & wr_bready;

  // Read FSM: arbitrate in idle, hold the grant through the last R beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RIdle;
      rd_gnt_q   <= 1'b0;
      rd_ptr_q   <= 1'b1;
    end else begin
      unique case (rd_state_q)
        RIdle: begin
          if (mem_i.arvalid | mem_d.arvalid) begin
            rd_gnt_q   <= pick(mem_i.arvalid, mem_d.arvalid, rd_ptr_q);
            rd_state_q <= RAddr;
          end
        end
        RAddr: if (rd_ar_hs) rd_state_q <= RData;
        RData: begin
          if (rd_last_hs) begin
            rd_ptr_q   <= rd_gnt_q;
            rd_state_q <= RIdle;
          end
        end
        default: rd_state_q <= RIdle;
      endcase
    end
  end

  // Write FSM: AW first, then W up to wlast, then the single B response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WIdle;
      wr_gnt_q   <= 1'b0;
      wr_ptr_q   <= 1'b1;
    end else begin
      unique case (wr_state_q)
        WIdle: begin
          if (mem_i.awvalid | mem_d.awvalid) begin
            wr_gnt_q   <= pick(mem_i.awvalid, mem_d.awvalid, wr_ptr_q);
            wr_state_q <= WAddr;
          end
        end
        WAddr: if (wr_aw_hs) wr_state_q <= WData;
        WData: if (wr_last_hs) wr_state_q <= WResp;
        WResp: begin
          if (wr_b_hs) begin
            wr_ptr_q   <= wr_gnt_q;
            wr_state_q <= WIdle;
          end
        end
        default: wr_state_q <= WIdle;
      endcase
    end
  end

  // Read routing: AR/R muxed by the registered grant, gated by state.
  always_comb begin
    rd_arvalid  = (rd_state_q == RAddr) & (rd_gnt_q ? mem_d.arvalid : mem_i.arvalid);
    rd_rready   = (rd_state_q == RData) & (rd_gnt_q ? mem_d.rready : mem_i.rready);
    axi.arvalid = rd_arvalid;
    axi.araddr  = rd_gnt_q ? mem_d.araddr  : mem_i.araddr;
    axi.arid    = rd_gnt_q ? mem_d.arid    : mem_i.arid;
    axi.arlen   = rd_gnt_q ? mem_d.arlen   : mem_i.arlen;
    axi.arburst = rd_gnt_q ? mem_d.arburst : mem_i.arburst;
    axi.arsize  = rd_gnt_q ? mem_d.arsize  : mem_i.arsize;
    axi.rready  = rd_rready;
    mem_i.arready = (rd_state_q == RAddr) & ~rd_gnt_q & axi.arready;
    mem_d.arready = (rd_state_q == RAddr) &  rd_gnt_q & axi.arready;
    mem_i.rvalid  = (rd_state_q == RData) & ~rd_gnt_q & axi.rvalid;
    mem_d.rvalid  = (rd_state_q == RData) &  rd_gnt_q & axi.rvalid;
    mem_i.rdata = axi.rdata;
    mem_i.rresp = axi.rresp;
    mem_i.rid   = axi.rid;
    mem_i.rlast = axi.rlast;
    mem_d.rdata = axi.rdata;
    mem_d.rresp = axi.rresp;
    mem_d.rid   = axi.rid;
    mem_d.rlast = axi.rlast;
  end

  // Write routing: W is held off both ports until the AW handshake is done.
  always_comb begin
    wr_awvalid  = (wr_state_q == WAddr) & (wr_gnt_q ? mem_d.awvalid : mem_i.awvalid);
    wr_wvalid   = (wr_state_q == WData) & (wr_gnt_q ? mem_d.wvalid : mem_i.wvalid);
    wr_bready   = (wr_state_q == WResp) & (wr_gnt_q ? mem_d.bready : mem_i.bready);
    axi.awvalid = wr_awvalid;
    axi.awaddr  = wr_gnt_q ? mem_d.awaddr  : mem_i.awaddr;
    axi.awid    = wr_gnt_q ? mem_d.awid    : mem_i.awid;
    axi.awlen   = wr_gnt_q ? mem_d.awlen   : mem_i.awlen;
    axi.awburst = wr_gnt_q ? mem_d.awburst : mem_i.awburst;
    axi.awsize  = wr_gnt_q ? mem_d.awsize  : mem_i.awsize;
    axi.wvalid  = wr_wvalid;
    axi.wdata   = wr_gnt_q ? mem_d.wdata : mem_i.wdata;
    axi.wstrb   = wr_gnt_q ? mem_d.wstrb : mem_i.wstrb;
    axi.wlast   = wr_gnt_q ? mem_d.wlast : mem_i.wlast;
    axi.bready  = wr_bready;
    mem_i.awready = (wr_state_q == WAddr) & ~wr_gnt_q & axi.awready;
    mem_d.awready = (wr_state_q == WAddr) &  wr_gnt_q & axi.awready;
    mem_i.wready  = (wr_state_q == WData) & ~wr_gnt_q & axi.wready;
    mem_d.wready  = (wr_state_q == WData) &  wr_gnt_q & axi.wready;
    mem_i.bvalid  = (wr_state_q == WResp) & ~wr_gnt_q & axi.bvalid;
    mem_d.bvalid  = (wr_state_q == WResp) &  wr_gnt_q & axi.bvalid;
    mem_i.bresp = axi.bresp;
    mem_i.bid   = axi.bid;
    mem_d.bresp = axi.bresp;
    mem_d.bid   = axi.bid;
  end

endmodule

// File: doc/psf_axi_arb2.md
# psf_axi_arb2

Two-port AXI4 arbiter directly downstream of the CPU top. It merges the instruction-fetch (`mem_i_*`) and data (`mem_d_*`) AXI master ports into one AXI4 master port toward the system interconnect. Read and write channels are arbitrated independently with round-robin priority. Each channel has one outstanding transaction at a time, and the grant is held until that transaction's last response handshake.

## Interface

Parameters:
- None. Widths are fixed: 32-bit address/data, 4-bit ID, 8-bit len.

Ports (direction relative to this block; `<p>` = `mem_i` or `mem_d`):
- `clk_i`  in  1  single clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `<p>_arvalid_i`, `_araddr_i`[32], `_arid_i`[4], `_arlen_i`[8], `_arburst_i`[2], `_arsize_i`[3]  in  read-address request from upstream port
- `<p>_arready_o`  out  1  read-address accept to upstream port
- `<p>_rvalid_o`, `_rdata_o`[32], `_rresp_o`[2], `_rid_o`[4], `_rlast_o`  out  read data to upstream port
- `<p>_rready_i`  in  1  upstream read-data ready
- `<p>_awvalid_i`, `_awaddr_i`[32], `_awid_i`[4], `_awlen_i`[8], `_awburst_i`[2], `_awsize_i`[3]  in  write-address request
- `<p>_awready_o`  out  1  write-address accept
- `<p>_wvalid_i`, `_wdata_i`[32], `_wstrb_i`[4], `_wlast_i`  in  write data
- `<p>_wready_o`  out  1  write-data accept
- `<p>_bvalid_o`, `_bresp_o`[2], `_bid_o`[4]  out  write response
- `<p>_bready_i`  in  1  upstream response ready
- `axi_ar*_o`, `axi_aw*_o`, `axi_w*_o`, `axi_rready_o`, `axi_bready_o`  out  merged master port, same field widths as above
- `axi_arready_i`, `axi_awready_i`, `axi_wready_i`, `axi_r*_i`, `axi_b*_i`  in  merged master port returns

## Operation

Read FSM (`R_IDLE`, `R_ADDR`, `R_DATA`):
- `R_IDLE`: if exactly one `<p>_arvalid_i` is high, grant that port. If both are high, grant the port not granted last (round-robin pointer). Register the grant, then go to `R_ADDR`.
- `R_ADDR`: `axi_arvalid_o` and all `axi_ar*` fields are driven combinationally from the granted port. `<granted>_arready_o` = `axi_arready_i`. On `axi_arvalid_o & axi_arready_i`, go to `R_DATA`.
- `R_DATA`: `<granted>_rvalid_o` = `axi_rvalid_i`; `axi_rready_o` = `<granted>_rready_i`. Non-granted `rvalid_o` = 0. `rdata/rresp/rid/rlast` are broadcast to both ports. On `axi_rvalid_i & axi_rready_o & axi_rlast_i`: update the round-robin pointer to the granted port, then go to `R_IDLE`.

Write FSM (`W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`):
- `W_IDLE`: same arbitration on `<p>_awvalid_i`, with its own pointer.
- `W_ADDR`: AW passthrough from the granted port. `wready_o` is forced to 0 on both ports, so W is never accepted before AW.
- `W_DATA`: W passthrough; `<granted>_wready_o` = `axi_wready_i`. A beat with `wlast` handshaken goes to `W_RESP`.
- `W_RESP`: B is routed to the granted port only (`bvalid_o` of the other port = 0). On the B handshake: update the pointer, then go to `W_IDLE`.

General rules:
- Non-granted ports, and all ports when their FSM is idle: `arready_o`/`awready_o`/`wready_o` = 0.
- `axi_*valid_o` is driven only in the matching state; it is 0 in every other state.
- Read and write FSMs never interact. A read from one port and a write from the other run concurrently.
- Response fields pass through unmodified, including `rresp`/`bresp` errors (SLVERR/DECERR). IDs are not altered.

## Timing

- Reset: both FSMs go to IDLE. Both round-robin pointers point at `mem_d`, so `mem_i` wins the first tie. Grant registers select `mem_i`. Every valid/ready output = 0. Field outputs follow `mem_i` inputs.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle N gives `axi_arvalid_o`/`axi_awvalid_o` = 1 at cycle N+1. Minimum read gap between back-to-back bursts is 1 idle cycle after `rlast`.
- Upstream masters hold valid/fields stable until ready, per AXI, so the registered grant is safe.
- A new request arriving in the same cycle as the completing last handshake is not granted until the following IDLE cycle.
- A reset asserted mid-burst aborts at the next edge: FSMs go to IDLE and outputs are deasserted. No drain is attempted; the downstream interconnect is reset in the same cycle.
- No combinational path from `axi_*ready_i` to `axi_*valid_o`.

## Test plan

- Single read: `mem_i` AR at 0x1FC00000, len=3 → `axi_arvalid_o` rises 1 cycle later with identical fields. 4 R beats reach `mem_i` only, with `mem_d_rvalid_o` = 0 throughout. FSM returns to IDLE after `rlast`.
- Tie and round-robin: both ports request reads continuously → grants alternate `mem_i`, `mem_d`, `mem_i`, `mem_d`, and no port is granted twice in a row.
- Write: `mem_d` AW 0x00001000 len=0 with W presented in the same cycle → `mem_d_wready_o` stays 0 until the AW handshake. Then 1 beat with `wstrb`=4'b0011 is forwarded. Inject `axi_bresp_i`=2'b10 → `mem_d_bresp_o`=2'b10, and `mem_i_bvalid_o` stays 0.
- Concurrency: `mem_i` read len=7 overlapping a `mem_d` write len=0 → both complete, beat counts are correct, and neither channel stalls the other.
- Backpressure: `axi_arready_i` low for 5 cycles, then `rready` toggled → `axi_arvalid_o` and fields stay stable. No beat is lost or duplicated.
- Reset mid-read: assert `rst_i` during beat 2 of 4 → on the next cycle all valid/ready outputs = 0 and the FSM is in IDLE. A post-reset tie grants `mem_i` first.
